shift_add_mult: RTL and testbench

//  Sequential shift-and-add unsigned multiplier core. Sits directly below the bus-mapped multiplier

---
 rtl/mult_pkg.sv | 10 +
 rtl/shift_add_mult_if.sv | 15 +
 rtl/shift_add_mult.sv | 105 ++++++++++
 tb/tb_shift_add_mult.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding and default width.
package mult_pkg;
    localparam int MULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/shift_add_mult_if.sv
// Operand/result bundle between the bus-mapped peripheral wrapper and the multiplier core.
interface shift_add_mult_if
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
);
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               init;
    logic [2*WIDTH-1:0] pp;
    logic               done;

    modport master (output A, B, init, input pp, done);
    modport slave  (input A, B, init, output pp, done);
endinterface

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier: one multiplier bit per clock, fixed latency,
// product register updated only when a result completes.
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    shift_add_mult_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int PW    = 2 * WIDTH;

    state_t             state;
    state_t             state_nxt;
    logic [PW-1:0]      acc;
    logic [PW-1:0]      a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [CNT_W-1:0]   cnt;
    logic [PW-1:0]      pp_r;
    logic               done_r;
    logic               start;
    logic               last;

    assign last     = (cnt == CNT_W'(WIDTH - 1));
    assign bus.pp   = pp_r;
    assign bus.done = done_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A restart from DONE is only taken once the result has been published (done high),
    // so the entry edge into DONE always captures the product.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.init) begin
                    start     = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (done_r && bus.init) begin
                    start     = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            cnt    <= '0;
            pp_r   <= '0;
            done_r <= 1'b0;
        end else if (start) begin
            a_sh   <= {{WIDTH{1'b0}}, bus.A};
            b_sh   <= bus.B;
            acc    <= '0;
            cnt    <= '0;
            done_r <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (b_sh[0]) begin
                        acc <= acc + a_sh;
                    end
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                end
                ST_DONE: begin
                    if (!done_r) begin
                        pp_r   <= acc;
                        done_r <= 1'b1;
                    end
                end
                ST_IDLE: begin
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_mult.sv
// Directed and randomised check of the shift-and-add multiplier with a product scoreboard.
module tb_shift_add_mult;
    import mult_pkg::*;

    localparam int W = 16;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    logic [2*W-1:0] exp_q[$];

    shift_add_mult_if #(.WIDTH(W)) bus ();

    shift_add_mult #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation: init on one edge, optional spurious init at RUN cycle glitch_at,
    // optional reset at RUN cycle abort_at; otherwise waits for done and scores pp.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int glitch_at, input int abort_at);
        logic [2*W-1:0] prev;
        logic [2*W-1:0] exp;
        bit             hold_ok;
        int             lat;
        prev    = bus.pp;
        hold_ok = 1'b1;
        lat     = 0;
        @(negedge clk);
        bus.A    = a;
        bus.B    = b;
        bus.init = 1'b1;
        exp_q.push_back((2*W)'(a) * (2*W)'(b));
        @(posedge clk);
        #1;
        check("done_drop", 64'(bus.done), 64'd0);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == glitch_at) begin
                bus.init = 1'b1;
                bus.A    = 16'd2;
                bus.B    = 16'd2;
            end else begin
                bus.init = 1'b0;
                bus.A    = ~a;
                bus.B    = ~b;
            end
            if (n == abort_at) begin
                rst = 1'b1;
                #1;
                check("abort_pp", 64'(bus.pp), 64'd0);
                check("abort_done", 64'(bus.done), 64'd0);
                void'(exp_q.pop_back());
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                break;
            end
            if (bus.pp !== prev) hold_ok = 1'b0;
        end
        check("latency", 64'(lat), 64'd17);
        check("pp_hold", 64'(hold_ok), 64'd1);
        check("sb_depth", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("product", 64'(bus.pp), 64'(exp));
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        bus.A      = '0;
        bus.B      = '0;
        bus.init   = 1'b0;
        #3;
        check("reset_pp", 64'(bus.pp), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_done", 64'(bus.done), 64'd0);

        run_op(16'd3, 16'd5, 0, 0);
        run_op(16'hFFFF, 16'hFFFF, 0, 0);
        check("max_product", 64'(bus.pp), 64'hFFFE_0001);
        run_op(16'h1234, 16'h0000, 0, 0);

        // Async reset between edges from a completed, nonzero result.
        run_op(16'd3, 16'd5, 0, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_pp", 64'(bus.pp), 64'd0);
        check("async_done", 64'(bus.done), 64'd0);
        #1;
        rst = 1'b0;

        run_op(16'd7, 16'd9, 5, 0);
        run_op(16'd100, 16'd200, 0, 8);
        repeat (4) @(negedge clk);
        check("post_abort_done", 64'(bus.done), 64'd0);
        check("post_abort_pp", 64'(bus.pp), 64'd0);
        run_op(16'd4, 16'd4, 0, 0);

        run_op(16'd3, 16'd5, 0, 0);
        run_op(16'd10, 16'd10, 0, 0);

        for (int i = 0; i < 1000; i++) begin
            run_op(16'($urandom), 16'($urandom), 0, 0);
        end

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
